// File: rtl/irq_pending_latch_if.sv
// rtl/irq_pending_latch_if.sv - request/acknowledge bundle for the pending interrupt latch
//
// Signals:
//   req[7:0]     raw request lines (bit 7 highest priority)
//   mask[7:0]    per-line output enable
//   ack_valid    one-cycle acknowledge pulse
//   ack_idx[2:0] encoded index being acknowledged (0 -> bit 7 ... 7 -> bit 0)
//   ovf_clr      clears all sticky overflow flags
//   D[7:0]       masked pending vector for the downstream priority encoder
//   irq          OR-reduction of D
//   ovf[7:0]     sticky per-line overflow flags
// Modports: master drives requests/acks, slave is the latch.
interface irq_pending_latch_if;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack_valid;
    logic [2:0] ack_idx;
    logic       ovf_clr;
    logic [7:0] D;
    logic       irq;
    logic [7:0] ovf;

    modport master (
        output req, mask, ack_valid, ack_idx, ovf_clr,
        input  D, irq, ovf
    );

    modport slave (
        input  req, mask, ack_valid, ack_idx, ovf_clr,
        output D, irq, ovf
    );
endinterface

// File: rtl/irq_pending_latch.sv
// rtl/irq_pending_latch.sv - edge-detecting pending interrupt latch with sticky overflow
//
// Parameters:
//   REQ_POL  asserted level of every req line (1 = active-high, 0 = active-low)
// Ports:
//   clk      single clock, rising edge
//   rst_n    asynchronous active-low reset
//   bus      irq_pending_latch_if.slave (req, mask, ack_valid, ack_idx, ovf_clr, D, irq, ovf)
// Build option:
//   IRQ_PENDING_SYNC_EN  inserts a 2-flop synchroniser per req bit ahead of req_s,
//                        raising request-to-D latency from 2 to 4 edges.
module irq_pending_latch #(
    parameter logic REQ_POL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    irq_pending_latch_if.slave   bus
);

    logic [7:0] w_req_norm;
    logic [7:0] w_req_in;
    logic [7:0] w_rise;
    logic [7:0] w_ack_mask;
    logic [7:0] w_ovf_set;
    logic [7:0] w_pending_nxt;
    logic [7:0] w_ovf_nxt;

    logic [7:0] r_req_s;
    logic [7:0] r_prev;
    logic [7:0] r_pending;
    logic [7:0] r_ovf;

    // Internally every asserted line reads as 1 regardless of polarity.
    assign w_req_norm = REQ_POL ? bus.req : ~bus.req;

`ifdef IRQ_PENDING_SYNC_EN
    logic [7:0] r_sync1;
    logic [7:0] r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 8'h00;
            r_sync2 <= 8'h00;
        end else begin
            r_sync1 <= w_req_norm;
            r_sync2 <= r_sync1;
        end
    end

    assign w_req_in = r_sync2;
`else
    assign w_req_in = w_req_norm;
`endif

    // Rising edge only: a level held high after an acknowledge does not re-arm.
    assign w_rise = r_req_s & ~r_prev;

    // ack_idx follows the downstream encoder's numbering, so index 0 is bit 7.
    assign w_ack_mask = bus.ack_valid ? (8'h80 >> bus.ack_idx) : 8'h00;

    // A rise on an already pending line is an overflow unless that line is
    // being acknowledged this cycle, in which case the new request simply
    // replaces the acknowledged one.
    assign w_ovf_set = w_rise & r_pending & ~w_ack_mask;

    // Set beats clear on both the pending and overflow registers.
    assign w_pending_nxt = (r_pending & ~w_ack_mask) | w_rise;
    assign w_ovf_nxt     = (r_ovf & ~{8{bus.ovf_clr}}) | w_ovf_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_s   <= 8'h00;
            r_prev    <= 8'h00;
            r_pending <= 8'h00;
            r_ovf     <= 8'h00;
        end else begin
            r_req_s   <= w_req_in;
            r_prev    <= r_req_s;
            r_pending <= w_pending_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

    // Mask gates only the presentation; masked lines keep latching.
    assign bus.D   = r_pending & bus.mask;
    assign bus.irq = |bus.D;
    assign bus.ovf = r_ovf;

endmodule

// File: tb/tb_irq_pending_latch.sv
// tb/tb_irq_pending_latch.sv - directed self-checking bench for irq_pending_latch
module tb_irq_pending_latch;

`ifdef IRQ_PENDING_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    irq_pending_latch_if bus ();
    irq_pending_latch_if bus0 ();

    irq_pending_latch #(.REQ_POL(1'b1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    irq_pending_latch #(.REQ_POL(1'b0)) u_dut_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] v);
        bus.req = v;
        tick();
        bus.req = 8'h00;
        repeat (LAT - 1) tick();
    endtask

    task automatic ack(input logic [2:0] idx);
        bus.ack_valid = 1'b1;
        bus.ack_idx   = idx;
        tick();
        bus.ack_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if (bus.D !== 8'h00) begin failures++; $display("FAIL reset_D got=%h exp=00", bus.D); end
        checks++;
        if (bus.irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", bus.irq); end
        checks++;
        if (bus.ovf !== 8'h00) begin failures++; $display("FAIL reset_ovf got=%h exp=00", bus.ovf); end
        checks++;
        if (bus0.D !== 8'h00) begin failures++; $display("FAIL reset_lo_D got=%h exp=00", bus0.D); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.req = 8'h20;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            bus.req = 8'h00;
            if (i < LAT) begin
                checks++;
                if (bus.D !== 8'h00) begin failures++; $display("FAIL single_early edge=%0d got=%h exp=00", i, bus.D); end
            end
        end
        checks++;
        if (bus.D !== 8'h20) begin failures++; $display("FAIL single_D got=%h exp=20", bus.D); end
        checks++;
        if (bus.irq !== 1'b1) begin failures++; $display("FAIL single_irq got=%b exp=1", bus.irq); end
        repeat (3) tick();
        checks++;
        if (bus.D !== 8'h20) begin failures++; $display("FAIL single_hold got=%h exp=20", bus.D); end
        ack(3'd2);
        checks++;
        if (bus.D !== 8'h00) begin failures++; $display("FAIL single_ack_D got=%h exp=00", bus.D); end
        checks++;
        if (bus.irq !== 1'b0) begin failures++; $display("FAIL single_ack_irq got=%b exp=0", bus.irq); end
    endtask

    task automatic test_multi();
        pulse(8'h81);
        checks++;
        if (bus.D !== 8'h81) begin failures++; $display("FAIL multi_D got=%h exp=81", bus.D); end
        ack(3'd0);
        checks++;
        if (bus.D !== 8'h01) begin failures++; $display("FAIL multi_ack0 got=%h exp=01", bus.D); end
        ack(3'd7);
        checks++;
        if (bus.D !== 8'h00) begin failures++; $display("FAIL multi_ack7 got=%h exp=00", bus.D); end
        ack(3'd5);
        checks++;
        if (bus.D !== 8'h00 || bus.ovf !== 8'h00) begin
            failures++; $display("FAIL ack_idle got D=%h ovf=%h exp D=00 ovf=00", bus.D, bus.ovf);
        end
    endtask

    task automatic test_overflow();
        pulse(8'h10);
        pulse(8'h10);
        checks++;
        if (bus.ovf !== 8'h10) begin failures++; $display("FAIL ovf_set got=%h exp=10", bus.ovf); end
        checks++;
        if (bus.D !== 8'h10) begin failures++; $display("FAIL ovf_D got=%h exp=10", bus.D); end
        repeat (2) tick();
        checks++;
        if (bus.ovf !== 8'h10) begin failures++; $display("FAIL ovf_sticky got=%h exp=10", bus.ovf); end
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        checks++;
        if (bus.ovf !== 8'h00) begin failures++; $display("FAIL ovf_clr got=%h exp=00", bus.ovf); end
        // rise and ack of bit 4 land on the same edge
        bus.req = 8'h10;
        tick();
        bus.req = 8'h00;
        repeat (LAT - 2) tick();
        bus.ack_valid = 1'b1;
        bus.ack_idx   = 3'd3;
        tick();
        bus.ack_valid = 1'b0;
        checks++;
        if (bus.D !== 8'h10) begin failures++; $display("FAIL rise_ack_D got=%h exp=10", bus.D); end
        checks++;
        if (bus.ovf !== 8'h00) begin failures++; $display("FAIL rise_ack_ovf got=%h exp=00", bus.ovf); end
        // new overflow on the same edge as ovf_clr
        bus.req = 8'h10;
        tick();
        bus.req = 8'h00;
        repeat (LAT - 2) tick();
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        checks++;
        if (bus.ovf !== 8'h10) begin failures++; $display("FAIL clr_vs_ovf got=%h exp=10", bus.ovf); end
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        ack(3'd3);
        checks++;
        if (bus.D !== 8'h00 || bus.ovf !== 8'h00) begin
            failures++; $display("FAIL ovf_cleanup got D=%h ovf=%h exp D=00 ovf=00", bus.D, bus.ovf);
        end
    endtask

    task automatic test_mask();
        bus.mask = 8'h00;
        pulse(8'h04);
        checks++;
        if (bus.D !== 8'h00) begin failures++; $display("FAIL mask_D got=%h exp=00", bus.D); end
        checks++;
        if (bus.irq !== 1'b0) begin failures++; $display("FAIL mask_irq got=%b exp=0", bus.irq); end
        bus.mask = 8'h04;
        #1;
        checks++;
        if (bus.D !== 8'h04) begin failures++; $display("FAIL unmask_D got=%h exp=04", bus.D); end
        checks++;
        if (bus.irq !== 1'b1) begin failures++; $display("FAIL unmask_irq got=%b exp=1", bus.irq); end
        ack(3'd5);
        bus.mask = 8'hFF;
        #1;
        checks++;
        if (bus.D !== 8'h00) begin failures++; $display("FAIL mask_ack got=%h exp=00", bus.D); end
    endtask

    task automatic test_polarity();
        bus0.req = 8'hFD;
        tick();
        bus0.req = 8'hFF;
        repeat (LAT - 1) tick();
        checks++;
        if (bus0.D !== 8'h02) begin failures++; $display("FAIL pol_lo_D got=%h exp=02", bus0.D); end
        checks++;
        if (bus0.irq !== 1'b1) begin failures++; $display("FAIL pol_lo_irq got=%b exp=1", bus0.irq); end
    endtask

    task automatic test_reset_held();
        rst_n   = 1'b0;
        bus.req = 8'hFF;
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            if (i < LAT) begin
                checks++;
                if (bus.D !== 8'h00) begin failures++; $display("FAIL held_early edge=%0d got=%h exp=00", i, bus.D); end
            end
        end
        checks++;
        if (bus.D !== 8'hFF) begin failures++; $display("FAIL held_D got=%h exp=FF", bus.D); end
        for (int i = 0; i < 8; i++) ack(i[2:0]);
        checks++;
        if (bus.D !== 8'h00) begin failures++; $display("FAIL held_ack_all got=%h exp=00", bus.D); end
        repeat (5) tick();
        checks++;
        if (bus.D !== 8'h00 || bus.ovf !== 8'h00) begin
            failures++; $display("FAIL held_stay got D=%h ovf=%h exp D=00 ovf=00", bus.D, bus.ovf);
        end
        bus.req = 8'h00;
        repeat (LAT) tick();
    endtask

    task automatic test_async_reset();
        pulse(8'h42);
        pulse(8'h02);
        checks++;
        if (bus.D !== 8'h42 || bus.ovf !== 8'h02) begin
            failures++; $display("FAIL pre_rst got D=%h ovf=%h exp D=42 ovf=02", bus.D, bus.ovf);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.D !== 8'h00) begin failures++; $display("FAIL async_rst_D got=%h exp=00", bus.D); end
        checks++;
        if (bus.ovf !== 8'h00) begin failures++; $display("FAIL async_rst_ovf got=%h exp=00", bus.ovf); end
        checks++;
        if (bus.irq !== 1'b0) begin failures++; $display("FAIL async_rst_irq got=%b exp=0", bus.irq); end
        tick();
        rst_n = 1'b1;
        repeat (LAT + 1) tick();
        checks++;
        if (bus.D !== 8'h00) begin failures++; $display("FAIL post_rst_D got=%h exp=00", bus.D); end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.req       = 8'h00;
        bus.mask      = 8'hFF;
        bus.ack_valid = 1'b0;
        bus.ack_idx   = 3'd0;
        bus.ovf_clr   = 1'b0;
        bus0.req       = 8'hFF;
        bus0.mask      = 8'hFF;
        bus0.ack_valid = 1'b0;
        bus0.ack_idx   = 3'd0;
        bus0.ovf_clr   = 1'b0;

        test_reset();
        test_polarity();
        test_single();
        test_multi();
        test_overflow();
        test_mask();
        test_reset_held();
        test_async_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_pending_latch.md
IRQ_PENDING_LATCH -- requirements
Module: irq_pending_latch

Interface
REQ-001 The block SHALL have parameter REQ_POL, default 1'b1, meaning the asserted level of every req line (1 = active-high, 0 = active-low).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 8 bits: raw request lines; bit 7 has the highest priority.
REQ-005 The block SHALL have port mask, input, 8 bits: per-line enable; 1 = presented downstream.
REQ-006 The block SHALL have port ack_valid, input, 1 bit: a one-cycle pulse that clears one pending line.
REQ-007 The block SHALL have port ack_idx, input, 3 bits: the encoded index being acknowledged (0 selects bit 7 … 7 selects bit 0, matching the downstream 8-to-3 priority encoder).
REQ-008 The block SHALL have port ovf_clr, input, 1 bit: a pulse that clears all overflow flags.
REQ-009 The block SHALL have port D, output, 8 bits: the masked pending vector, driven directly into the priority encoder's D input.
REQ-010 The block SHALL have port irq, output, 1 bit: the OR-reduction of D.
REQ-011 The block SHALL have port ovf, output, 8 bits: sticky per-line overflow flags.

Function
REQ-012 Each req bit SHALL be normalised with REQ_POL, so that an asserted line reads as 1 internally.
REQ-013 The normalised req SHALL be sampled into req_s on every edge, and req_s SHALL be delayed once more into prev.
REQ-014 A rise SHALL be defined as rise[i] = req_s[i] & ~prev[i]. A level held asserted SHALL NOT re-set pending[i] after an acknowledge.
REQ-015 pending[i] SHALL be set at the edge following a cycle in which rise[i] = 1.
REQ-016 Latency from req asserted before edge k to D[i] = 1 SHALL be 2 edges (valid after edge k+1) when the mask bit is set.
REQ-017 ack_valid = 1 at edge k SHALL clear pending[7-ack_idx] at edge k, and the cleared bit SHALL appear on D after that edge.
REQ-018 When a rise and an acknowledge hit the same bit in the same cycle, the set SHALL win: pending stays 1 and ovf is not set.
REQ-019 An acknowledge of a bit that is not pending SHALL have no effect and SHALL NOT be flagged as an error.
REQ-020 When rise[i] = 1 while pending[i] = 1 and bit i is not acknowledged in that cycle, ovf[i] SHALL be set at the next edge.
REQ-021 ovf bits SHALL remain set until an ovf_clr pulse.
REQ-022 When ovf_clr and a new overflow occur in the same cycle, the new overflow SHALL win and the bit SHALL remain 1.
REQ-023 mask SHALL gate only the output, D = pending & mask (combinational from registers). Masked lines SHALL still latch pending and ovf, so unmasking presents a stored request immediately.
REQ-024 irq SHALL be the combinational OR of D, with no extra latency.
REQ-025 Multiple simultaneous rises SHALL all latch in the same cycle; prioritisation is left entirely to the downstream encoder.

Reset
REQ-026 While rst_n = 0, req_s, prev, pending and ovf SHALL asynchronously go to 0, giving D = 0, irq = 0 and ovf = 0.
REQ-027 Deassertion of rst_n SHALL be used synchronously by all flops.
REQ-028 Because prev resets to 0, a line held asserted through reset release SHALL be captured once, 2 edges after release.
REQ-029 Reset asserted mid-operation SHALL discard all pending and ovf state without generating any output pulse.

Configuration
REQ-030 When macro IRQ_PENDING_SYNC_EN is defined, a 2-flop synchroniser SHALL be inserted per bit ahead of req_s, making the REQ-016 latency 4 edges; these flops SHALL also reset to 0.
REQ-031 When IRQ_PENDING_SYNC_EN is undefined, req SHALL be treated as synchronous to clk and the latency SHALL be 2 edges.
REQ-032 The rest of the behaviour SHALL be identical in both builds.

Verification
REQ-033 Scenario: mask=8'hFF; req=8'h20 pulse of 1 cycle -> D=8'h20 and irq=1 exactly 2 edges later (4 with the macro); D holds until ack_valid with ack_idx=3'd2, then D=8'h00 and irq=0.
REQ-034 Scenario: req=8'h81 rising together -> D=8'h81; ack_idx=0 -> D=8'h01; ack_idx=7 -> D=8'h00.
REQ-035 Scenario: req bit 4 second rise before ack -> ovf=8'h10; ovf_clr pulse -> ovf=8'h00; rise and ack on bit 4 in the same cycle -> pending stays, ovf=8'h00.
REQ-036 Scenario: mask=8'h00, req=8'h04 pulse -> D=8'h00 and irq=0; then mask=8'h04 -> D=8'h04 in the same cycle.
REQ-037 Scenario: req=8'hFF held through reset release -> D=8'hFF once; ack all eight -> D=8'h00 and stays 0 while req is held.
REQ-038 Scenario: REQ_POL=0, req idles at 8'hFF, bit 1 driven low -> D=8'h02.
REQ-039 Scenario: rst_n asserted mid-operation with D=8'h42, ovf=8'h02 -> both 0 immediately (asynchronously).
